alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Sequential 8x8 unsigned multiplier that acts as the initiator for the team's combinational 8-bit ALU. It accepts an operand pair on a valid/ready port and drives opcode and operands to an external ALU instance every cycle. It builds the 16-bit product by shift-and-add using only the ALU's ADD and SHR operations, then returns the product on a valid/ready result port.

## Interface
- No parameters: width fixed at 8-bit operands and a 16-bit product.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_valid  in  1  operand pair offered
- start_ready  out  1  high only in IDLE
- op_a  in  8  multiplicand
- op_b  in  8  multiplier
- alu_oper  out  3  ALU opcode (000 ADD, 001 INC, 010 SUB, 011 DEC, 100 SHL, 101 SHR, 110 NAND, 111 GT)
- alu_a  out  8  ALU operand A
- alu_b  out  8  ALU operand B
- alu_out  in  8  ALU result, combinational in the same cycle
- alu_cy  in  1  ALU carry: ADD carry-out; for SHR, A[0]
- res_valid  out  1  product available
- res_ready  in  1  consumer accepts product
- product  out  16  {hi, lo}, stable while res_valid=1

## Operation
- Internal registers:
  - state (IDLE, ADD, SHR_HI, SHR_LO, DONE)
  - hi[7:0], lo[7:0], mcand[7:0]
  - c (1 bit, add carry)
  - s (1 bit, saved hi LSB)
  - iter[2:0]
- IDLE:
  - Drives alu_oper=000, alu_a=0, alu_b=0.
  - On start_valid&&start_ready: hi<=0, lo<=op_b, mcand<=op_a, iter<=0, c<=0, go to ADD.
- ADD:
  - Drives alu_oper=000, alu_a=hi, alu_b=mcand.
  - If lo[0]=1: hi<=alu_out, c<=alu_cy.
  - Else: hi unchanged, c<=0.
  - Go to SHR_HI.
- SHR_HI:
  - Drives alu_oper=101, alu_a=hi, alu_b=0.
  - hi<={c, alu_out[6:0]}, s<=alu_cy. Go to SHR_LO.
- SHR_LO:
  - Drives alu_oper=101, alu_a=lo, alu_b=0.
  - lo<={s, alu_out[6:0]}.
  - If iter==7: go to DONE. Else iter<=iter+1 and go to ADD.
- DONE:
  - res_valid=1, product={hi,lo}. ALU outputs as in IDLE.
  - On res_ready=1: go to IDLE.
- Arithmetic:
  - All values are unsigned. c is the 9th bit of each partial add.
  - After 8 iterations {hi,lo}=op_a*op_b exactly. No overflow is possible: max 0xFF*0xFF=0xFE01.
- The sequencer never uses INC, SUB, DEC, SHL, NAND or GT opcodes.
- Inputs are ignored outside their states:
  - start_valid while not IDLE is ignored; it is neither latched nor queued.
  - res_ready outside DONE is ignored.
- Operands are sampled only on the accepting edge. Changes to op_a/op_b afterward have no effect.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE; hi, lo, mcand, c, s and iter = 0.
  - res_valid=0, product=0, start_ready=1 once state is IDLE.
  - alu_oper=000, alu_a=0, alu_b=0.
- Reset mid-operation discards the operation; no result is ever produced for it.
- All outputs are decoded from registered state and registers only. No combinational path exists from start_valid or res_ready to any output.
- start_ready=(state==IDLE).
- Latency is fixed at 24 cycles, independent of operand values:
  - The accepting edge is E0. E1..E24 cover 8 iterations of 3 cycles each.
  - res_valid is high from just after E24.
- res_valid holds with product stable until the edge where res_ready=1 is sampled. Then res_valid=0 and start_ready=1 on the next cycle.
- No same-cycle result-to-start overlap. Minimum spacing between accepts is 26 cycles with res_ready held high.
- ALU loop is combinational in the same cycle: alu_out/alu_cy are consumed at the edge ending the cycle in which alu_oper/alu_a/alu_b are driven.

## Test plan
- op_a=0x0D, op_b=0x0B, res_ready=1 -> res_valid after exactly 24 cycles, product=0x008F. Bench checks that ADD cycles drive alu_oper=000, alu_a=hi, alu_b=0x0D, and shift cycles drive 101.
- op_a=0xFF, op_b=0xFF -> product=0xFE01. Exercises carry propagation c into hi[7].
- op_a=0x00, op_b=0xFF and op_a=0xA5, op_b=0x00 -> product=0x0000 for both. op_a=0x01, op_b=0x80 -> 0x0080.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> product and res_valid stay stable and start_ready=0. Raising res_ready -> IDLE on the next cycle. A held start_valid with new operands 0x03/0x05 is accepted then and yields 0x000F.
- start_valid pulsed at cycle 5 of a busy operation with 0x77/0x77 -> ignored; the original result is unchanged.
- rst_n asserted at cycle 10 of an operation -> all outputs zero immediately with no res_valid. After release, a new 0x12*0x34 operation yields 0x03A8.

Source files
------------

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - sequential 8x8 shift-and-add multiplier driving an external ALU
//
// Builds a 16-bit unsigned product from two 8-bit operands using only the
// ADD and SHR operations of an external combinational ALU. Each of the eight
// iterations takes three cycles (ADD, SHR_HI, SHR_LO), so a result is ready
// exactly 24 cycles after the accepting edge.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start_valid/start_ready operand handshake; ready only while idle
//   op_a, op_b              multiplicand, multiplier (sampled on accept)
//   alu_oper, alu_a, alu_b  opcode and operands driven to the external ALU
//   alu_out, alu_cy         ALU result and carry, same-cycle combinational
//   res_valid/res_ready     result handshake
//   product                 {hi, lo}; zero except while res_valid is high
module alu_mul_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic [7:0]  op_a,
   input  logic [7:0]  op_b,
   output logic [2:0]  alu_oper,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   input  logic [7:0]  alu_out,
   input  logic        alu_cy,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] product
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SHR = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADD    = 3'd1,
      ST_SHR_HI = 3'd2,
      ST_SHR_LO = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t     state;
   logic [7:0] hi;
   logic [7:0] lo;
   logic [7:0] mcand;
   logic       c;
   logic       s;
   logic [2:0] iter;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         hi    <= 8'd0;
         lo    <= 8'd0;
         mcand <= 8'd0;
         c     <= 1'b0;
         s     <= 1'b0;
         iter  <= 3'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_valid) begin
                  hi    <= 8'd0;
                  lo    <= op_b;
                  mcand <= op_a;
                  iter  <= 3'd0;
                  c     <= 1'b0;
                  state <= ST_ADD;
               end
            end
            ST_ADD: begin
               // c is the 9th bit of the partial sum; it is shifted into hi[7] next.
               if (lo[0]) begin
                  hi <= alu_out;
                  c  <= alu_cy;
               end else begin
                  c  <= 1'b0;
               end
               state <= ST_SHR_HI;
            end
            ST_SHR_HI: begin
               // alu_cy carries the bit falling out of hi into lo[7].
               hi    <= {c, alu_out[6:0]};
               s     <= alu_cy;
               state <= ST_SHR_LO;
            end
            ST_SHR_LO: begin
               lo <= {s, alu_out[6:0]};
               if (iter == 3'd7) begin
                  state <= ST_DONE;
               end else begin
                  iter  <= iter + 3'd1;
                  state <= ST_ADD;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs depend only on registered state, never on the handshake inputs.
   always_comb begin
      alu_oper    = OP_ADD;
      alu_a       = 8'd0;
      alu_b       = 8'd0;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      product     = 16'd0;
      case (state)
         ST_IDLE: begin
            start_ready = 1'b1;
         end
         ST_ADD: begin
            alu_a = hi;
            alu_b = mcand;
         end
         ST_SHR_HI: begin
            alu_oper = OP_SHR;
            alu_a    = hi;
         end
         ST_SHR_LO: begin
            alu_oper = OP_SHR;
            alu_a    = lo;
         end
         ST_DONE: begin
            res_valid = 1'b1;
            product   = {hi, lo};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq with an ALU model
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic [2:0]  alu_oper;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [7:0]  alu_out;
   logic        alu_cy;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] product;

   int checks = 0;
   int errors = 0;

   alu_mul_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .alu_oper    (alu_oper),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_out     (alu_out),
      .alu_cy      (alu_cy),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .product     (product)
   );

   always #5 clk = ~clk;

   // External combinational ALU
   always_comb begin
      alu_out = 8'd0;
      alu_cy  = 1'b0;
      case (alu_oper)
         3'b000: {alu_cy, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         3'b001: alu_out = alu_a + 8'd1;
         3'b010: alu_out = alu_a - alu_b;
         3'b011: alu_out = alu_a - 8'd1;
         3'b100: begin alu_out = alu_a << 1; alu_cy = alu_a[7]; end
         3'b101: begin alu_out = alu_a >> 1; alu_cy = alu_a[0]; end
         3'b110: alu_out = ~(alu_a & alu_b);
         default: alu_out = (alu_a > alu_b) ? 8'd1 : 8'd0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Offers an operand pair and returns just after the accepting edge.
   task automatic accept(input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      start_valid = 1'b1;
      op_a = a;
      op_b = b;
      while (!start_ready && n < 100) begin
         tick;
         n++;
      end
      chk("accept_ready", {31'd0, start_ready}, 32'd1);
      tick;
      start_valid = 1'b0;
      op_a = 8'($urandom);
      op_b = 8'($urandom);
   endtask

   // Partial product over the low i multiplier bits.
   function automatic int part(input int a, input int b, input int i);
      return a * (b % (1 << i));
   endfunction

   // Follows an accepted operation until res_valid, checking the ALU drive
   // against the shift-and-add partial products and the final product.
   task automatic run_result(input logic [7:0] a8, input logic [7:0] b8, input int pulse_at);
      int ia = int'(a8);
      int ib = int'(b8);
      int k = 0;
      int it;
      int v;
      while (!res_valid && k < 40) begin
         if (k < 24) begin
            it = k / 3;
            case (k % 3)
               0: begin
                  chk("add_oper", {29'd0, alu_oper}, 32'd0);
                  chk("add_a_hi", {24'd0, alu_a}, (part(ia, ib, it) >> it) & 32'hFF);
                  chk("add_b_mcand", {24'd0, alu_b}, ia);
               end
               1: begin
                  chk("shr_hi_oper", {29'd0, alu_oper}, 32'd5);
                  chk("shr_hi_a", {24'd0, alu_a}, (part(ia, ib, it + 1) >> it) & 32'hFF);
               end
               default: begin
                  v = (part(ia, ib, it) << (8 - it)) | (ib >> it);
                  chk("shr_lo_oper", {29'd0, alu_oper}, 32'd5);
                  chk("shr_lo_a", {24'd0, alu_a}, v & 32'hFF);
               end
            endcase
            chk("busy_no_ready", {31'd0, start_ready}, 32'd0);
         end
         if (k == pulse_at) begin
            start_valid = 1'b1;
            op_a = 8'h77;
            op_b = 8'h77;
         end else if (k == pulse_at + 1) begin
            start_valid = 1'b0;
         end
         tick;
         k++;
      end
      chk("latency", k, 24);
      chk("res_valid", {31'd0, res_valid}, 32'd1);
      chk("product", {16'd0, product}, ia * ib);
   endtask

   task automatic consume;
      res_ready = 1'b1;
      tick;
      chk("post_valid", {31'd0, res_valid}, 32'd0);
      chk("post_ready", {31'd0, start_ready}, 32'd1);
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      int seen;

      rst_n = 1'b0;
      start_valid = 1'b0;
      op_a = 8'd0;
      op_b = 8'd0;
      res_ready = 1'b1;
      tick;
      tick;
      chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_product", {16'd0, product}, 32'd0);
      chk("rst_alu_oper", {29'd0, alu_oper}, 32'd0);
      chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
      chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
      rst_n = 1'b1;
      tick;

      // Directed cases
      accept(8'h0D, 8'h0B); run_result(8'h0D, 8'h0B, -10);
      chk("prod_0d_0b", {16'd0, product}, 32'h008F);
      consume;
      accept(8'hFF, 8'hFF); run_result(8'hFF, 8'hFF, -10);
      chk("prod_ff_ff", {16'd0, product}, 32'hFE01);
      consume;
      accept(8'h00, 8'hFF); run_result(8'h00, 8'hFF, -10); consume;
      accept(8'hA5, 8'h00); run_result(8'hA5, 8'h00, -10); consume;
      accept(8'h01, 8'h80); run_result(8'h01, 8'h80, -10);
      chk("prod_01_80", {16'd0, product}, 32'h0080);
      consume;

      // Random operands
      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         accept(ra, rb);
         run_result(ra, rb, -10);
         consume;
      end

      // start_valid pulsed mid-operation is ignored
      accept(8'h0D, 8'h0B);
      run_result(8'h0D, 8'h0B, 5);
      consume;

      // Backpressure with a held start request
      res_ready = 1'b0;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      accept(ra, rb);
      run_result(ra, rb, -10);
      start_valid = 1'b1;
      op_a = 8'h03;
      op_b = 8'h05;
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("bp_valid", {31'd0, res_valid}, 32'd1);
         chk("bp_product", {16'd0, product}, int'(ra) * int'(rb));
         chk("bp_start_ready", {31'd0, start_ready}, 32'd0);
      end
      consume;
      tick;
      start_valid = 1'b0;
      run_result(8'h03, 8'h05, -10);
      chk("prod_03_05", {16'd0, product}, 32'h000F);
      consume;

      // Reset mid-operation
      accept(8'hC3, 8'h5A);
      for (int i = 0; i < 10; i++) tick;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
      chk("mid_rst_product", {16'd0, product}, 32'd0);
      chk("mid_rst_oper", {29'd0, alu_oper}, 32'd0);
      chk("mid_rst_a", {24'd0, alu_a}, 32'd0);
      chk("mid_rst_b", {24'd0, alu_b}, 32'd0);
      chk("mid_rst_ready", {31'd0, start_ready}, 32'd1);
      tick;
      #2;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (res_valid) seen++;
      end
      chk("no_result_after_rst", seen, 0);
      accept(8'h12, 8'h34);
      run_result(8'h12, 8'h34, -10);
      chk("prod_12_34", {16'd0, product}, 32'h03A8);
      consume;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
